// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the shared data memory: fixed priority for the
// CPU port, starvation counter and short locked bursts for the secondary master.
module dmem_arbiter #(
  parameter int AW           = 24,
  parameter int DW           = 24,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  input  logic          p1_lock,
  output logic          p1_gnt,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_rvalid,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writedata,
  output logic          mem_writeenable,
  output logic          mem_MemRead,
  input  logic [DW-1:0] mem_data,
  output logic [1:0]    owner
);

  typedef enum logic [0:0] {IDLE = 1'b0, P1_LOCK = 1'b1} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

  state_t      state_r, state_s;
  logic [3:0]  starve_cnt_r;
  logic [7:0]  beat_cnt_r, beat_cnt_s;
  logic        starving_s, p0_gnt_s, p1_gnt_s;

  assign starving_s = (starve_cnt_r == STARVE_MAX);
  // Grants are forced low while reset is asserted so nothing is accepted across it.
  assign p0_gnt = p0_gnt_s & rst_n;
  assign p1_gnt = p1_gnt_s & rst_n;

  // Next-state and grant decode.
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    p0_gnt_s   = 1'b0;
    p1_gnt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (p0_req && !starving_s) begin
          p0_gnt_s = 1'b1;
        end else if (p1_req) begin
          p1_gnt_s = 1'b1;
        end else begin
          p1_gnt_s = 1'b0;
        end
        if (p1_gnt_s && p1_lock && (MAX_BURST > 1)) begin
          state_s    = P1_LOCK;
          beat_cnt_s = 8'd1;
        end else begin
          beat_cnt_s = 8'd0;
        end
      end
      P1_LOCK: begin
        p1_gnt_s = p1_req;
        if (!p1_req || !p1_lock || ((beat_cnt_r + 8'd1) == BURST_MAX)) begin
          state_s    = IDLE;
          beat_cnt_s = 8'd0;
        end else begin
          beat_cnt_s = beat_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        beat_cnt_s = 8'd0;
      end
    endcase
  end

  // State, burst and starvation counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      beat_cnt_r   <= 8'd0;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      if (!p1_req || p1_gnt_s) begin
        starve_cnt_r <= 4'd0;
      end else if (!starving_s) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Memory-side command register; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address     <= '0;
      mem_writedata   <= '0;
      mem_writeenable <= 1'b0;
      mem_MemRead     <= 1'b0;
      owner           <= 2'b00;
    end else if (p0_req && p0_gnt_s) begin
      mem_address     <= p0_addr;
      mem_writedata   <= p0_wdata;
      mem_writeenable <= p0_we;
      mem_MemRead     <= !p0_we;
      owner           <= 2'b01;
    end else if (p1_req && p1_gnt_s) begin
      mem_address     <= p1_addr;
      mem_writedata   <= p1_wdata;
      mem_writeenable <= p1_we;
      mem_MemRead     <= !p1_we;
      owner           <= 2'b10;
    end else begin
      mem_writeenable <= 1'b0;
      mem_MemRead     <= 1'b0;
      owner           <= 2'b00;
    end
  end

  // Read return: capture memory data at the end of the memory cycle for its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rdata  <= '0;
      p0_rvalid <= 1'b0;
      p1_rdata  <= '0;
      p1_rvalid <= 1'b0;
    end else begin
      p0_rvalid <= mem_MemRead && (owner == 2'b01);
      p1_rvalid <= mem_MemRead && (owner == 2'b10);
      if (mem_MemRead && (owner == 2'b01)) begin
        p0_rdata <= mem_data;
      end else begin
        p0_rdata <= p0_rdata;
      end
      if (mem_MemRead && (owner == 2'b10)) begin
        p1_rdata <= mem_data;
      end else begin
        p1_rdata <= p1_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a falling-edge memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [23:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [23:0] p0_rdata, p1_rdata;
  logic [23:0] mem_address, mem_writedata, mem_data;
  logic        mem_writeenable, mem_MemRead;
  logic [1:0]  owner;
  logic [23:0] mem [0:4095];
  logic        written [0:4095];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_writeenable(mem_writeenable), .mem_MemRead(mem_MemRead),
    .mem_data(mem_data), .owner(owner)
  );

  function automatic logic [23:0] init_word(input logic [11:0] a);
    case (a)
      12'h020: init_word = 24'h001234;
      12'h060: init_word = 24'h00AAAA;
      12'h061: init_word = 24'h00BBBB;
      default: init_word = 24'h000000;
    endcase
  endfunction

  // Memory model: samples on the falling edge, cleared while reset is low.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
      mem_data <= 24'h0;
    end else begin
      if (mem_writeenable) begin
        mem[mem_address[11:0]]     <= mem_writedata;
        written[mem_address[11:0]] <= 1'b1;
      end
      if (mem_MemRead)
        mem_data <= written[mem_address[11:0]] ? mem[mem_address[11:0]] : init_word(mem_address[11:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000010; p0_wdata = 24'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 24'h0; p1_wdata = 24'h0; p1_lock = 1'b0;
    step(); step();
    n_checks++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_p0_gnt got %b exp 0", p0_gnt); end
    n_checks++; if ({mem_writeenable, mem_MemRead, owner, p0_rvalid, p1_rvalid} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 0", {mem_writeenable, mem_MemRead, owner, p0_rvalid, p1_rvalid}); end
    n_checks++; if ({mem_address, mem_writedata, p0_rdata, p1_rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {mem_address, mem_writedata, p0_rdata, p1_rdata}); end
  endtask

  task automatic test_reset_mid_read();
    rst_n = 1'b1;
    #1;
    n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got %b exp 1", p0_gnt); end
    step(); p0_req = 1'b0;
    n_checks++; if ({mem_MemRead, owner, mem_address} !== {1'b1, 2'b01, 24'h000010}) begin n_fail++; $display("FAIL midrst_issue got %h exp %h", {mem_MemRead, owner, mem_address}, {1'b1, 2'b01, 24'h000010}); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_MemRead, owner, mem_address, p0_rvalid} !== 28'h0) begin n_fail++; $display("FAIL midrst_async got %h exp 0", {mem_MemRead, owner, mem_address, p0_rvalid}); end
    step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rvalid cyc %0d got %b exp 0", i, p0_rvalid); end
    end
  endtask

  task automatic test_single_read();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000020;
    #1;
    n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt got %b exp 1", p0_gnt); end
    step(); p0_req = 1'b0;
    n_checks++; if ({mem_MemRead, mem_writeenable, owner, mem_address, p0_rvalid} !== {1'b1, 1'b0, 2'b01, 24'h000020, 1'b0}) begin n_fail++; $display("FAIL single_issue got %h", {mem_MemRead, mem_writeenable, owner, mem_address, p0_rvalid}); end
    step();
    n_checks++; if ({p0_rvalid, p0_rdata, mem_MemRead, owner} !== {1'b1, 24'h001234, 1'b0, 2'b00}) begin n_fail++; $display("FAIL single_return got %h exp %h", {p0_rvalid, p0_rdata, mem_MemRead, owner}, {1'b1, 24'h001234, 1'b0, 2'b00}); end
    step();
    n_checks++; if ({p0_rvalid, p0_rdata} !== {1'b0, 24'h001234}) begin n_fail++; $display("FAIL single_hold got %h exp %h", {p0_rvalid, p0_rdata}, {1'b0, 24'h001234}); end
  endtask

  task automatic test_contention();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000030;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000040; p1_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if ({p0_gnt, p1_gnt} !== ((i % 5 == 4) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL contention cyc %0d got p0/p1 %b exp %b", i, {p0_gnt, p1_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
      end
      step();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_burst();
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 24'h000100; p1_wdata = 24'h000A00;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL burst_first got %b exp 01", {p0_gnt, p1_gnt}); end
    step();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000050;
    for (int k = 1; k < 8; k++) begin
      p1_addr = 24'h000100 + 24'(k); p1_wdata = 24'h000A00 + 24'(k);
      #1;
      n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL burst_beat %0d got %b exp 01", k, {p0_gnt, p1_gnt}); end
      n_checks++; if ({mem_writeenable, owner, mem_address} !== {1'b1, 2'b10, 24'h000100 + 24'(k - 1)}) begin n_fail++; $display("FAIL burst_mem %0d got %h exp %h", k, {mem_writeenable, owner, mem_address}, {1'b1, 2'b10, 24'h000100 + 24'(k - 1)}); end
      step();
    end
    p1_addr = 24'h000108; p1_wdata = 24'h000A08;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++; $display("FAIL burst_release got %b exp 10", {p0_gnt, p1_gnt}); end
    step(); p0_req = 1'b0;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt, owner} !== 4'b0101) begin n_fail++; $display("FAIL burst_resume got %b exp 0101", {p0_gnt, p1_gnt, owner}); end
    step(); p1_req = 1'b0; p1_lock = 1'b0;
    #1;
    n_checks++; if ({mem_address, mem_writeenable} !== {24'h000108, 1'b1}) begin n_fail++; $display("FAIL burst_resume_mem got %h exp %h", {mem_address, mem_writeenable}, {24'h000108, 1'b1}); end
    n_checks++; if ({written[12'h107], mem[12'h107]} !== {1'b1, 24'h000A07}) begin n_fail++; $display("FAIL burst_memword got %h exp %h", {written[12'h107], mem[12'h107]}, {1'b1, 24'h000A07}); end
    step(); step();
  endtask

  task automatic test_early_end();
    p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_addr = 24'h000200; p1_wdata = 24'h000B00;
    step();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000020; p1_addr = 24'h000201;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL early_beat2 got %b exp 01", {p0_gnt, p1_gnt}); end
    step(); p1_addr = 24'h000202; p1_lock = 1'b0;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL early_beat3 got %b exp 01", {p0_gnt, p1_gnt}); end
    step(); p1_addr = 24'h000203;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin n_fail++; $display("FAIL early_p0 got %b exp 10", {p0_gnt, p1_gnt}); end
    step(); p0_req = 1'b0;
    #1;
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin n_fail++; $display("FAIL early_p1_again got %b exp 01", {p0_gnt, p1_gnt}); end
    step(); p1_req = 1'b0;
    step(); step(); step();
  endtask

  task automatic test_back_to_back();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000060;
    #1;
    n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_a_gnt got %b exp 1", p0_gnt); end
    step(); p0_req = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000061; p1_lock = 1'b0;
    #1;
    n_checks++; if ({p1_gnt, mem_MemRead, owner, mem_address} !== {1'b1, 1'b1, 2'b01, 24'h000060}) begin n_fail++; $display("FAIL b2b_b got %h", {p1_gnt, mem_MemRead, owner, mem_address}); end
    step(); p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h000062; p0_wdata = 24'h00CCCC;
    #1;
    n_checks++; if ({p0_gnt, mem_MemRead, mem_writeenable, owner, mem_address} !== {1'b1, 1'b1, 1'b0, 2'b10, 24'h000061}) begin n_fail++; $display("FAIL b2b_c got %h", {p0_gnt, mem_MemRead, mem_writeenable, owner, mem_address}); end
    n_checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 24'h00AAAA}) begin n_fail++; $display("FAIL b2b_ret_a got %h exp %h", {p0_rvalid, p0_rdata}, {1'b1, 24'h00AAAA}); end
    step(); p0_req = 1'b0;
    n_checks++; if ({p1_rvalid, p1_rdata, p0_rvalid} !== {1'b1, 24'h00BBBB, 1'b0}) begin n_fail++; $display("FAIL b2b_ret_b got %h exp %h", {p1_rvalid, p1_rdata, p0_rvalid}, {1'b1, 24'h00BBBB, 1'b0}); end
    n_checks++; if ({mem_writeenable, mem_MemRead, mem_address, mem_writedata} !== {1'b1, 1'b0, 24'h000062, 24'h00CCCC}) begin n_fail++; $display("FAIL b2b_write got %h", {mem_writeenable, mem_MemRead, mem_address, mem_writedata}); end
    step();
    n_checks++; if ({mem_writeenable, p0_rvalid, p1_rvalid} !== 3'b000) begin n_fail++; $display("FAIL b2b_after got %b exp 000", {mem_writeenable, p0_rvalid, p1_rvalid}); end
    n_checks++; if (mem[12'h062] !== 24'h00CCCC) begin n_fail++; $display("FAIL b2b_memword got %h exp 00cccc", mem[12'h062]); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_single_read();
    test_contention();
    test_burst();
    test_early_end();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
